// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Receives a framed coefficient set over an 8-bit valid/ready byte stream
//   and writes it into the FIR filter's coefficient port. The filter stays in
//   load mode (c_WE=1) until every coefficient has been written and the
//   trailing XOR checksum has matched.
//
//   Frame: HDR, NC coefficients of NB=C/8 bytes each (MSB byte first),
//   then one checksum byte equal to the XOR of all coefficient bytes.
//
// Ports
//   clk      in   system clock (shared with the filter)
//   nrst     in   synchronous active-low reset
//   s_data   in   stream byte
//   s_valid  in   stream byte valid
//   s_ready  out  loader can take a byte this cycle
//   c_WE     out  coefficient write enable to the filter (1 = load mode)
//   c_addr   out  coefficient address, 0..NC-1
//   c_in     out  coefficient value
//   done     out  a verified set is loaded and the filter is running
//   err      out  last frame aborted (bad checksum or timeout)
//
// Parameter constraints: C is 8 or 16, 2**AW >= NC.
module fir_coeff_loader #(
   parameter int         NC  = 129,
   parameter int         C   = 16,
   parameter int         AW  = 8,
   parameter logic [7:0] HDR = 8'hA5,
   parameter int         TO  = 1024
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [7:0]    s_data,
   input  logic          s_valid,
   output logic          s_ready,
   output logic          c_WE,
   output logic [AW-1:0] c_addr,
   output logic [C-1:0]  c_in,
   output logic          done,
   output logic          err
);

   localparam int NB = C / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TW = $clog2(TO + 1);

   localparam logic [BW-1:0] B_LAST = BW'(NB - 1);
   localparam logic [AW-1:0] K_LAST = AW'(NC - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TO - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      COMMIT = 3'd2,
      CHECK  = 3'd3,
      RUN    = 3'd4
   } state_t;

   // Running checksum: bytewise XOR.
   function automatic logic [7:0] xsum_fold(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

   // Shift one byte into the low end of the assembly word (MSB byte arrives first).
   function automatic logic [C-1:0] shift_in(input logic [C-1:0] word, input logic [7:0] data);
      return C'({word, data});
   endfunction

   state_t          state_r, state_s;
   logic [AW-1:0]   k_r, k_s;
   logic [BW-1:0]   b_r, b_s;
   logic [C-1:0]    asm_r, asm_s;
   logic [7:0]      xsum_r, xsum_s;
   logic [TW-1:0]   tcnt_r, tcnt_s;
   logic            ready_r, ready_s;
   logic            we_r, we_s;
   logic [AW-1:0]   addr_r, addr_s;
   logic [C-1:0]    cin_r, cin_s;
   logic            done_r, done_s;
   logic            err_r, err_s;
   logic            accept_s;

   assign s_ready = ready_r;
   assign c_WE    = we_r;
   assign c_addr  = addr_r;
   assign c_in    = cin_r;
   assign done    = done_r;
   assign err     = err_r;

   // Next-state and next-output computation for the frame parser.
   always_comb begin
      state_s  = state_r;
      k_s      = k_r;
      b_s      = b_r;
      asm_s    = asm_r;
      xsum_s   = xsum_r;
      tcnt_s   = tcnt_r;
      we_s     = we_r;
      addr_s   = addr_r;
      cin_s    = cin_r;
      done_s   = done_r;
      err_s    = err_r;
      accept_s = s_valid & ready_r;

      case (state_r)
         IDLE, RUN: begin
            tcnt_s = {TW{1'b0}};
            if (accept_s && (s_data == HDR)) begin
               // Start of a new frame: back into load mode, clear everything.
               state_s = LOAD;
               k_s     = {AW{1'b0}};
               b_s     = {BW{1'b0}};
               asm_s   = {C{1'b0}};
               xsum_s  = 8'h00;
               err_s   = 1'b0;
               we_s    = 1'b1;
               done_s  = 1'b0;
            end else begin
               state_s = state_r;
            end
         end

         LOAD: begin
            if (accept_s) begin
               asm_s  = shift_in(asm_r, s_data);
               xsum_s = xsum_fold(xsum_r, s_data);
               tcnt_s = {TW{1'b0}};
               if (b_r == B_LAST) begin
                  state_s = COMMIT;
               end else begin
                  b_s = b_r + BW'(1);
               end
            end else if (tcnt_r == T_LAST) begin
               state_s = IDLE;
               err_s   = 1'b1;
               we_s    = 1'b1;
               done_s  = 1'b0;
            end else begin
               tcnt_s = tcnt_r + TW'(1);
            end
         end

         COMMIT: begin
            // No byte can arrive here (s_ready=0), so the idle count keeps
            // running from the last accept.
            addr_s = k_r;
            cin_s  = asm_r;
            b_s    = {BW{1'b0}};
            tcnt_s = tcnt_r + TW'(1);
            if (k_r == K_LAST) begin
               state_s = CHECK;
            end else begin
               k_s     = k_r + AW'(1);
               state_s = LOAD;
            end
         end

         CHECK: begin
            if (accept_s) begin
               tcnt_s = {TW{1'b0}};
               if (s_data == xsum_r) begin
                  state_s = RUN;
                  we_s    = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  state_s = IDLE;
                  err_s   = 1'b1;
                  we_s    = 1'b1;
                  done_s  = 1'b0;
               end
            end else if (tcnt_r == T_LAST) begin
               state_s = IDLE;
               err_s   = 1'b1;
               we_s    = 1'b1;
               done_s  = 1'b0;
            end else begin
               tcnt_s = tcnt_r + TW'(1);
            end
         end

         default: begin
            state_s = IDLE;
            tcnt_s  = {TW{1'b0}};
            we_s    = 1'b1;
            done_s  = 1'b0;
         end
      endcase

      // Stall the stream only while a coefficient is being presented.
      ready_s = (state_s != COMMIT);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_r <= IDLE;
         k_r     <= {AW{1'b0}};
         b_r     <= {BW{1'b0}};
         asm_r   <= {C{1'b0}};
         xsum_r  <= 8'h00;
         tcnt_r  <= {TW{1'b0}};
         ready_r <= 1'b0;
         we_r    <= 1'b1;
         addr_r  <= {AW{1'b0}};
         cin_r   <= {C{1'b0}};
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         k_r     <= k_s;
         b_r     <= b_s;
         asm_r   <= asm_s;
         xsum_r  <= xsum_s;
         tcnt_r  <= tcnt_s;
         ready_r <= ready_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         cin_r   <= cin_s;
         done_r  <= done_s;
         err_r   <= err_s;
      end
   end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Upstream companion to the FIR lowpass filter (`fir`). It receives a byte stream with a valid/ready handshake, carrying a framed coefficient set. It assembles the bytes into C-bit coefficients and drives the filter's c_WE / c_addr / c_in coefficient port. The filter is held in load mode (c_WE=1) until a complete, checksum-verified set has been written.

Parameters:
- NC, 129, number of unique coefficients written (ORD=257 symmetric → (ORD+1)/2); addresses 0..NC-1.
- C, 16, coefficient width; must be 8 or 16; NB = C/8 bytes per coefficient, MSB byte first.
- AW, 8, c_addr width; requires 2^AW ≥ NC.
- HDR, 8'hA5, frame header byte.
- TO, 1024, inter-byte timeout in clk cycles during a frame.

Ports:
- clk  in  1  system clock (same clock as fir).
- nrst  in  1  reset, synchronous, active-low.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader can accept a byte; transfer occurs when s_valid & s_ready at posedge clk.
- c_WE  out  1  coefficient write enable to fir; fir writes c_in at c_addr on every clk while high.
- c_addr  out  AW  coefficient address.
- c_in  out  C  coefficient value.
- done  out  1  level: a verified set is loaded and the filter is running.
- err  out  1  sticky: last frame was aborted (checksum or timeout); cleared by the next header.

Behaviour:
- Reset values (nrst=0 at posedge): state IDLE, c_WE=1, c_addr=0, c_in=0, done=0, err=0, s_ready=0. All counters and the checksum are zeroed. Reset mid-frame discards the frame.
- s_ready: 1 in every state except the single cycle after reset release and the COMMIT cycle (see below).
- States:
  - IDLE (no set loaded): accepted bytes ≠ HDR are discarded. HDR → LOAD with coef index k=0, byte index b=0, xsum=0, err cleared.
  - LOAD: each accepted byte shifts into the assembly register (MSB first) and is XORed into xsum; b increments.
    - On byte NB-1 of coefficient k → COMMIT.
  - COMMIT (1 cycle, s_ready=0): c_addr←k, c_in←assembled word. These update together, exactly 1 cycle after the last byte's accept edge.
    - If k=NC-1 → CHECK; else k++, b=0, → LOAD.
    - Between commits, c_addr/c_in hold the last committed pair. Repeated fir writes of that pair are idempotent.
    - Before the first commit, address 0 holds 0; coefficient 0 overwrites it.
  - CHECK: the next accepted byte is compared with xsum (XOR of all NC*NB coefficient bytes; header excluded).
    - Match → RUN: c_WE←0 and done←1 on the edge after the accept.
    - Mismatch → IDLE with err←1, c_WE stays 1, done=0. The filter never runs on a partial or corrupt set.
  - RUN: c_WE=0, done=1; non-header bytes are discarded.
    - HDR → LOAD: c_WE←1 and done←0 on the next edge, err cleared, counters reset.
- Timeout: in LOAD/CHECK, a counter increments each cycle with no accepted byte and resets on each accept.
  - When it reaches TO → IDLE, err←1, c_WE=1, done=0.
  - An accept in the same cycle the count reaches TO wins: the byte is taken and there is no timeout.
- HDR inside a frame (LOAD/CHECK) is ordinary data, not a restart.
- c_addr never exceeds NC-1. Frame length is fixed; extra bytes after the checksum are handled by the IDLE/RUN rules.

Test Plan:
- Load 0x0102: reset, then stream A5 + 129×(01,02) + checksum 03, s_valid continuous.
  - 129 commits with c_addr 0..128 and c_in=16'h0102.
  - c_WE falls 1 cycle after the checksum accept; done=1, err=0.
- Bad checksum: same frame with checksum 04 → err=1, done=0, c_WE stays 1, state IDLE. A following correct frame → done=1, err=0.
- Ramp coefficients with gaps: coefficient k = k*3, MSB first, with random s_valid gaps < TO.
  - Each commit shows c_addr=k, c_in=k*3 exactly 1 cycle after the second byte.
  - s_ready=0 only in COMMIT cycles; final RUN reached.
- Timeout: stall s_valid after coefficient 40 → err=1 exactly TO cycles after the last accept, c_WE=1. Bytes 00, 5A then a correct frame → loads normally.
- Reload from RUN: send A5 → c_WE=1 and done=0 the next cycle, then a full valid load returns to RUN. A lone 5A in RUN is ignored.
- Reset mid-load: assert nrst=0 for 1 cycle during coefficient 60.
  - All outputs return to reset values on that edge.
  - A subsequent complete frame succeeds with correct c_addr/c_in sequence.
